// File: rtl/uart_baud_gen.sv
// Fractional baud-tick generator: a phase accumulator produces oversample, mid-bit
// and bit-end ticks for the UART engines from a runtime-selectable baud table.
module uart_baud_gen #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int OVERSAMPLE  = 16,
    parameter int ACC_W       = 32,
    parameter int DEFAULT_SEL = 3
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       en,
    input  logic       sync,
    input  logic [3:0] baud_sel,
    output logic       tick_os,
    output logic       tick_mid,
    output logic       tick_bit,
    output logic       baud_err
);

    localparam int              CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       SEL_RST  = 4'(DEFAULT_SEL);

    function automatic logic [63:0] baud_of(input int idx);
        case (idx)
            0:       return 64'd1200;
            1:       return 64'd2400;
            2:       return 64'd4800;
            3:       return 64'd9600;
            4:       return 64'd19200;
            5:       return 64'd28800;
            6:       return 64'd38400;
            7:       return 64'd57600;
            8:       return 64'd76800;
            9:       return 64'd115200;
            10:      return 64'd230400;
            11:      return 64'd460800;
            12:      return 64'd921600;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic is_legal(input int idx);
        return (idx <= 12) && ((baud_of(idx) * 64'(OVERSAMPLE)) < 64'(CLK_FREQ));
    endfunction

    // Rounded-to-nearest phase increment, evaluated only at elaboration.
    function automatic logic [ACC_W-1:0] inc_of(input int idx);
        logic [63:0] num;
        num = (baud_of(idx) * 64'(OVERSAMPLE)) << ACC_W;
        return ACC_W'((num + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ));
    endfunction

    logic [ACC_W-1:0] inc_tab [16];
    logic [15:0]      legal_tab;

    for (genvar i = 0; i < 16; i++) begin : g_tab
        assign legal_tab[i] = is_legal(i);
        assign inc_tab[i]   = is_legal(i) ? inc_of(i) : inc_of(DEFAULT_SEL);
    end

    logic [3:0]       sel_q;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] os_cnt;
    logic [ACC_W:0]   sum;
    logic             carry;

    assign sum   = {1'b0, acc} + {1'b0, inc_tab[sel_q]};
    assign carry = sum[ACC_W];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sel_q    <= SEL_RST;
            acc      <= '0;
            os_cnt   <= '0;
            tick_os  <= 1'b0;
            tick_mid <= 1'b0;
            tick_bit <= 1'b0;
            baud_err <= 1'b0;
        end else if (sync || (baud_sel != sel_q)) begin
            // Restart realigns the phase and re-registers the selection together.
            sel_q    <= baud_sel;
            baud_err <= ~legal_tab[baud_sel];
            acc      <= '0;
            os_cnt   <= '0;
            tick_os  <= 1'b0;
            tick_mid <= 1'b0;
            tick_bit <= 1'b0;
        end else if (!en) begin
            tick_os  <= 1'b0;
            tick_mid <= 1'b0;
            tick_bit <= 1'b0;
        end else begin
            acc      <= sum[ACC_W-1:0];
            tick_os  <= carry;
            tick_mid <= carry && (os_cnt == CNT_MID);
            tick_bit <= carry && (os_cnt == CNT_LAST);
            if (carry) begin
                os_cnt <= (os_cnt == CNT_LAST) ? '0 : os_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: table of per-rate vectors, hand-written corner sequences,
// randomized stimulus against an arithmetic tick model, and a long-run rate check.
module tb_uart_baud_gen;

    localparam longint unsigned CLK_A = 64'd614400;
    localparam longint unsigned CLK_B = 64'd50000000;
    localparam int              N_B   = 50000;

    logic       clk = 1'b0;
    logic       arst;
    logic       en;
    logic       sync;
    logic [3:0] sel;
    logic       tick_os, tick_mid, tick_bit, baud_err;
    logic       b_rst;
    logic       b_os, b_mid, b_bit, b_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_baud_gen #(.CLK_FREQ(614400), .OVERSAMPLE(16), .ACC_W(32), .DEFAULT_SEL(3)) dut_a (
        .clk(clk), .arst(arst), .en(en), .sync(sync), .baud_sel(sel),
        .tick_os(tick_os), .tick_mid(tick_mid), .tick_bit(tick_bit), .baud_err(baud_err)
    );

    uart_baud_gen #(.CLK_FREQ(50_000_000), .OVERSAMPLE(16), .ACC_W(32), .DEFAULT_SEL(3)) dut_b (
        .clk(clk), .arst(b_rst), .en(1'b1), .sync(1'b0), .baud_sel(4'd9),
        .tick_os(b_os), .tick_mid(b_mid), .tick_bit(b_bit), .baud_err(b_err)
    );

    // Reference model: ticks follow from the count of whole carries k*INC/2^32
    // after k enabled cycles since the last restart.
    int              m_sel;
    longint unsigned m_k;
    logic            m_err;
    logic [3:0]      exp_q[$];

    function automatic longint unsigned baud_hz(int s);
        case (s)
            0: return 1200;      1: return 2400;      2: return 4800;
            3: return 9600;      4: return 19200;     5: return 28800;
            6: return 38400;     7: return 57600;     8: return 76800;
            9: return 115200;    10: return 230400;   11: return 460800;
            12: return 921600;   default: return 0;
        endcase
    endfunction

    function automatic bit legal(longint unsigned f, int s);
        return (s <= 12) && (baud_hz(s) * 16 < f);
    endfunction

    function automatic longint unsigned inc_for(longint unsigned f, int s);
        int e;
        e = legal(f, s) ? s : 3;
        return (baud_hz(e) * 16 * (64'd1 << 32) + f / 2) / f;
    endfunction

    task automatic model_step();
        logic [3:0]      e;
        longint unsigned inc, c0, c1;
        logic            os;
        if (sync || (int'(sel) != m_sel)) begin
            m_k   = 0;
            m_sel = int'(sel);
            m_err = !legal(CLK_A, m_sel);
            e     = {3'b000, m_err};
        end else if (!en) begin
            e = {3'b000, m_err};
        end else begin
            inc = inc_for(CLK_A, m_sel);
            m_k = m_k + 1;
            c1  = (m_k * inc) >> 32;
            c0  = ((m_k - 1) * inc) >> 32;
            os  = (c1 != c0);
            e   = {os, os && (c1 % 16 == 8), os && (c1 % 16 == 0), m_err};
        end
        exp_q.push_back(e);
    endtask

    task automatic check(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step();
        logic [3:0] exp, got;
        model_step();
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        got = {tick_os, tick_mid, tick_bit, baud_err};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL model t=%0t {os,mid,bit,err} got=%b exp=%b", $time, got, exp);
        end
    endtask

    task automatic run(input int n, output int first_os, output int n_os, output int n_bit,
                       output int first_mid, output int first_bit);
        first_os = -1; first_mid = -1; first_bit = -1; n_os = 0; n_bit = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (tick_os) begin
                n_os++;
                if (first_os < 0) first_os = i;
            end
            if (tick_mid && first_mid < 0) first_mid = i;
            if (tick_bit) begin
                n_bit++;
                if (first_bit < 0) first_bit = i;
            end
        end
    endtask

    task automatic do_reset(input logic [3:0] s);
        arst = 1'b1; en = 1'b1; sync = 1'b0; sel = s;
        repeat (2) @(posedge clk);
        #2;
        arst  = 1'b0;
        m_sel = 3; m_k = 0; m_err = 1'b0;
        exp_q.delete();
    endtask

    typedef struct {
        int sel;
        int first_os;
        int n_os;
        int n_bit;
        int err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int fo, no, nb, fm, fb;
        int b_cnt_os, b_cnt_mid, b_cnt_bit;
        longint unsigned b_exp;

        b_rst = 1'b1;
        vecs = '{'{0, 32, 4, 0, 0}, '{1, 16, 8, 0, 0}, '{2, 8, 16, 1, 0},
                 '{3, 4, 32, 2, 0}, '{4, 2, 64, 4, 0}, '{5, 2, 96, 6, 0},
                 '{6, 4, 32, 2, 1}, '{12, 4, 32, 2, 1}, '{15, 4, 32, 2, 1}};

        // Reset values and the nominal 9600-baud schedule.
        do_reset(4'd3);
        check("reset_outputs", {tick_os, tick_mid, tick_bit, baud_err}, 0);
        run(128, fo, no, nb, fm, fb);
        check("s1_first_os", fo, 4);
        check("s1_os_count", no, 32);
        check("s1_first_mid", fm, 32);
        check("s1_first_bit", fb, 64);
        check("s1_bit_count", nb, 2);

        // Per-rate vectors, each started with a sync restart.
        foreach (vecs[v]) begin
            sel  = 4'(vecs[v].sel);
            sync = 1'b1;
            step();
            sync = 1'b0;
            check($sformatf("vec%0d_err", v), baud_err, vecs[v].err);
            run(128, fo, no, nb, fm, fb);
            check($sformatf("vec%0d_first_os", v), fo, vecs[v].first_os);
            check($sformatf("vec%0d_os_count", v), no, vecs[v].n_os);
            check($sformatf("vec%0d_bit_count", v), nb, vecs[v].n_bit);
        end

        // Sync held over edges 30..32 keeps everything cleared.
        do_reset(4'd3);
        run(29, fo, no, nb, fm, fb);
        sync = 1'b1;
        run(3, fo, no, nb, fm, fb);
        check("sync_held_ticks", no, 0);
        sync = 1'b0;
        run(64, fo, no, nb, fm, fb);
        check("sync_first_os", fo, 4);
        check("sync_first_bit", fb, 64);

        // Hold over edges 6..15 shifts the schedule by 10 cycles.
        do_reset(4'd3);
        run(5, fo, no, nb, fm, fb);
        check("hold_pre_count", no, 1);
        en = 1'b0;
        run(10, fo, no, nb, fm, fb);
        check("hold_ticks", no, 0);
        en = 1'b1;
        run(69, fo, no, nb, fm, fb);
        check("hold_next_os", fo, 3);
        check("hold_first_bit", fb, 59);
        check("hold_post_count", no, 17);

        // Illegal selection falls back to 9600, then a legal change clears the flag.
        do_reset(4'd3);
        sel = 4'd14;
        step();
        check("err_set", baud_err, 1);
        run(16, fo, no, nb, fm, fb);
        check("err_first_os", fo, 4);
        check("err_os_count", no, 4);
        sel = 4'd5;
        step();
        check("err_clear", baud_err, 0);
        run(8, fo, no, nb, fm, fb);
        check("sel5_first_os", fo, 2);
        check("sel5_os_count", no, 6);

        // Asynchronous reset while a tick and the error flag are high.
        do_reset(4'd14);
        run(1, fo, no, nb, fm, fb);
        run(4, fo, no, nb, fm, fb);
        check("pre_arst_tick", tick_os, 1);
        check("pre_arst_err", baud_err, 1);
        #2;
        arst = 1'b1;
        #1;
        check("arst_outputs", {tick_os, tick_mid, tick_bit, baud_err}, 0);
        @(posedge clk);
        sel = 4'd3;
        #2;
        arst  = 1'b0;
        m_sel = 3; m_k = 0; m_err = 1'b0;
        run(128, fo, no, nb, fm, fb);
        check("post_arst_first_os", fo, 4);
        check("post_arst_first_bit", fb, 64);
        check("post_arst_os_count", no, 32);

        // Randomized en/sync/baud_sel traffic against the model.
        do_reset(4'd3);
        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            sync = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 59) == 0) sel = 4'($urandom_range(0, 15));
            step();
        end
        en = 1'b1; sync = 1'b0;

        // Long-run rate at 115200 baud from a 50 MHz clock.
        @(posedge clk);
        #2;
        b_rst = 1'b0;
        b_cnt_os = 0; b_cnt_mid = 0; b_cnt_bit = 0;
        for (int i = 0; i < N_B; i++) begin
            @(posedge clk);
            #1;
            if (b_os) b_cnt_os++;
            if (b_mid) b_cnt_mid++;
            if (b_bit) b_cnt_bit++;
        end
        b_exp = (longint'(N_B) * inc_for(CLK_B, 9)) >> 32;
        check("b_os_exact", b_cnt_os, longint'(b_exp));
        check("b_os_nominal_within_1", (b_cnt_os >= 1842 && b_cnt_os <= 1844) ? 1 : 0, 1);
        check("b_bit_exact", b_cnt_bit, longint'(b_exp / 16));
        check("b_mid_exact", b_cnt_mid, longint'((b_exp + 8) / 16));
        check("b_err", b_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
